dual_sram_seq_clear: RTL

Parametrised successor to the team's dual-port SRAM used to hold dotProduct operand and result vectors.
- One write port and one read port, with a configurable read latency of 1 or 2 cycles.
- Read_Valid qualifier on read data.
- Configurable behaviour when a read and a write hit the same address in the same cycle.
- Mem_Clear runs a hardware clear sequencer that zeroes the array one word per cycle; Clear_Busy is high while it runs.
- Sits between the file-loading bench or host loader and the dot-product datapath.

---
 rtl/dsram_pkg.sv | 18 +
 rtl/dsram_read_pipe.sv | 52 +++++
 rtl/dual_sram_seq_clear.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dsram_pkg.sv
// Shared types and helpers for the dual-port SRAM with clear sequencer.
// Holds the FSM state type, collision-mode encodings and the parity helper.
package dsram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } dsram_state_t;

  localparam int COLL_READ_OLD    = 0;
  localparam int COLL_WRITE_FIRST = 1;

  // Even-parity bit over a zero-extended word (words up to 256 bits).
  function automatic logic parity_even(input logic [255:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dsram_read_pipe.sv
// Read-data delay line: LAT (1 or 2) register stages carrying valid and data.
// Latency LAT cycles; no backpressure, one entry accepted per cycle.
// Output data loads only on valid so it holds between reads; reset clears valids and the visible output.
module dsram_read_pipe #(
  parameter int LAT = 1,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic         last_vld;
  logic [W-1:0] last_dat;

  generate
    if (LAT == 1) begin : g_direct
      assign last_vld = in_vld;
      assign last_dat = in_dat;
    end else begin : g_stage
      logic         mid_vld;
      logic [W-1:0] mid_dat;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) mid_vld <= 1'b0;
        else     mid_vld <= in_vld;
      end

      always_ff @(posedge clk) begin
        if (in_vld) mid_dat <= in_dat;
      end

      assign last_vld = mid_vld;
      assign last_dat = mid_dat;
    end
  endgenerate

  // The final data stage is the architectural Read_Data register, so it resets too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      out_vld <= last_vld;
      if (last_vld) out_dat <= last_dat;
    end
  end

endmodule

// File: rtl/dual_sram_seq_clear.sv
// Dual-port SRAM (1W/1R) with hardware clear sequencer; optional parity via DSRAM_PARITY_EN.
// Read latency READ_LATENCY (1 or 2) cycles, one read per cycle; clear takes DEPTH cycles.
// No backpressure: user requests arriving during a clear are dropped, in-flight reads still drain.
module dual_sram_seq_clear
  import dsram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_Clear,
  input  logic                  Chip_Select,
  input  logic                  En_Write,
  input  logic                  En_Read,
  input  logic [ADDR_WIDTH-1:0] Write_Addr,
  input  logic [ADDR_WIDTH-1:0] Read_Addr,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  Read_Valid,
  output logic                  Clear_Busy
`ifdef DSRAM_PARITY_EN
  ,
  output logic                  Parity_Err
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef DSRAM_PARITY_EN
  localparam int PIPE_W = DATA_WIDTH + 1;
`else
  localparam int PIPE_W = DATA_WIDTH;
`endif

  dsram_state_t          state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem_dat [DEPTH];

  logic                  wr_en;
  logic                  rd_en;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic [PIPE_W-1:0]     pipe_in;
  logic [PIPE_W-1:0]     pipe_out;

  assign wr_en  = (state == IDLE) && Chip_Select && En_Write;
  assign rd_en  = (state == IDLE) && Chip_Select && En_Read;
  assign bypass = (COLLISION_MODE == COLL_WRITE_FIRST) && wr_en && rd_en &&
                  (Write_Addr == Read_Addr);
  assign rd_dat = bypass ? Write_Data : mem_dat[Read_Addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      Clear_Busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Mem_Clear) begin
            state      <= CLEAR;
            Clear_Busy <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (&clr_cnt) begin
            state      <= IDLE;
            Clear_Busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          Clear_Busy <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; an aborted clear leaves it partially zeroed.
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem_dat[clr_cnt]    <= '0;
    else if (wr_en)      mem_dat[Write_Addr] <= Write_Data;
  end

`ifdef DSRAM_PARITY_EN
  logic mem_par [DEPTH];
  logic rd_perr;

  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem_par[clr_cnt]    <= 1'b0;
    else if (wr_en)      mem_par[Write_Addr] <= parity_even(256'(Write_Data));
  end

  // Bypassed data never came from the array, so it cannot carry a stored error.
  assign rd_perr  = !bypass &&
                    (mem_par[Read_Addr] != parity_even(256'(mem_dat[Read_Addr])));
  assign pipe_in  = {rd_perr, rd_dat};
  assign Read_Data  = pipe_out[DATA_WIDTH-1:0];
  assign Parity_Err = Read_Valid && pipe_out[DATA_WIDTH];
`else
  assign pipe_in   = rd_dat;
  assign Read_Data = pipe_out;
`endif

  dsram_read_pipe #(
    .LAT (READ_LATENCY),
    .W   (PIPE_W)
  ) u_read_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_en),
    .in_dat  (pipe_in),
    .out_vld (Read_Valid),
    .out_dat (pipe_out)
  );

endmodule
